// File: rtl/colour_pkg.sv
// colour_pkg: shared widths, named colour codes and slot states for the colour ROM front end
package colour_pkg;
  localparam int COL_W = 3;
  localparam int RGB_W = 24;
  typedef enum logic [COL_W-1:0] {BLACK, BLUE, GREEN, CYAN, RED, MAGENTA, YELLOW, WHITE} colour_e;
  typedef enum logic [1:0] {IDLE, FLIGHT, HOLD} slot_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; on a tie the requester not granted most recently wins
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] eligible,
  output logic [1:0] grant
);
  logic ptr_q, ptr_d;
  always_comb begin
    grant = (&eligible) ? (ptr_q ? 2'b10 : 2'b01) : eligible;
    ptr_d = (|grant) ? grant[0] : ptr_q;
  end
  always_ff @(posedge clk) ptr_q <= rst ? 1'b0 : ptr_d;
endmodule

// File: rtl/colour_rom_arbiter.sv
// colour_rom_arbiter: lets two requesters share one 1-cycle colour ROM, buffering each result until accepted
module colour_rom_arbiter #(
  parameter int COL_W = colour_pkg::COL_W,
  parameter int RGB_W = colour_pkg::RGB_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [COL_W-1:0] req0_colour,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic [RGB_W-1:0] rsp0_rgb,
  input  logic             rsp0_ready,
  input  logic             req1_valid,
  input  logic [COL_W-1:0] req1_colour,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [RGB_W-1:0] rsp1_rgb,
  input  logic             rsp1_ready,
  output logic             rom_en,
  output logic [COL_W-1:0] rom_addr,
  input  logic [RGB_W-1:0] rom_rgb
);
  import colour_pkg::*;
  logic [1:0] req_v, rsp_r, elig, grant;
  logic [COL_W-1:0] col [2];
  slot_e st_q [2];
  slot_e st_d [2];
  logic [RGB_W-1:0] rgb_q [2];
  logic [RGB_W-1:0] rgb_d [2];
  logic fl_v_q, fl_id_q;
  assign req_v  = {req1_valid, req0_valid};
  assign rsp_r  = {rsp1_ready, rsp0_ready};
  assign col[0] = req0_colour;
  assign col[1] = req1_colour;
  // a held slot can release and re-accept in the same cycle
  always_comb begin
    elig = '0;
    for (int n = 0; n < 2; n++)
      elig[n] = !rst && req_v[n] && (st_q[n] == IDLE || (st_q[n] == HOLD && rsp_r[n]));
  end
  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .eligible (elig),
    .grant    (grant)
  );
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      st_d[n] = st_q[n];
      if (grant[n]) st_d[n] = FLIGHT;
      else if (st_q[n] == FLIGHT) st_d[n] = HOLD;
      else if (st_q[n] == HOLD && rsp_r[n]) st_d[n] = IDLE;
      rgb_d[n] = (fl_v_q && fl_id_q == n[0]) ? rom_rgb : rgb_q[n];
    end
  end
  // clearing the owner tag on reset discards ROM data still arriving
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= '{IDLE, IDLE};
      rgb_q   <= '{default: '0};
      fl_v_q  <= 1'b0;
      fl_id_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      rgb_q   <= rgb_d;
      fl_v_q  <= |grant;
      fl_id_q <= grant[1];
    end
  end
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp0_valid = st_q[0] == HOLD;
  assign rsp1_valid = st_q[1] == HOLD;
  assign rsp0_rgb   = rgb_q[0];
  assign rsp1_rgb   = rgb_q[1];
  assign rom_en     = |grant;
  assign rom_addr   = grant[1] ? col[1] : grant[0] ? col[0] : '0;
endmodule

// File: doc/colour_rom_arbiter.md
# colour_rom_arbiter

Two-requester round-robin arbiter and response buffer in front of the shared 8-entry colour-to-RGB ROM (synchronous read, 1-cycle latency, enable-gated, read-only). It lets two independent clients, such as an LED driver and a display scanner, share one ROM instance. The block sequences one lookup per cycle, tracks which requester owns the in-flight read, and holds each result in a per-requester register until that requester accepts it.

## Interface
- `COL_W`, default 3: colour code / ROM address width.
- `RGB_W`, default 24: RGB word width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has a lookup pending.
- `req0_colour` in COL_W: colour code for requester 0.
- `req0_ready` out 1: requester 0 lookup accepted this cycle.
- `rsp0_valid` out 1: `rsp0_rgb` holds a result.
- `rsp0_rgb` out RGB_W: RGB result for requester 0.
- `rsp0_ready` in 1: requester 0 consumes its result.
- `req1_*`, `rsp1_*`: identical set for requester 1.
- `rom_en` out 1: ROM read enable.
- `rom_addr` out COL_W: ROM address.
- `rom_rgb` in RGB_W: ROM data, valid the cycle after `rom_en`.

## Operation
- Each requester has a slot FSM with three states:
  - IDLE: nothing outstanding.
  - FLIGHT: ROM read issued, data arrives next cycle.
  - HOLD: `rsp_valid` is 1 and the result is waiting for the requester.
- A requester is eligible in a cycle when `req_valid` is 1 and either its slot is IDLE, or its slot is HOLD with `rsp_ready` 1 (release and accept in the same cycle).
- Arbitration:
  - If exactly one requester is eligible, it is granted.
  - If both are eligible, grant the one not granted most recently.
  - After reset the round-robin pointer favours requester 0.
  - The pointer updates only on a grant.
- Grant outputs:
  - `reqN_ready` = 1 for the granted requester only; it is combinational from valid and state.
  - `rom_en` = 1 and `rom_addr` = the granted colour.
- With no grant, `rom_en` = 0 and `rom_addr` = 0.
- Accepting a request moves that slot to FLIGHT. Next cycle `rom_rgb` is captured into `rspN_rgb` and the slot moves to HOLD.
- In HOLD, `rsp_valid`/`rsp_rgb` stay stable until the `rsp_valid & rsp_ready` handshake. The slot then goes to IDLE, or to FLIGHT if a new accept happens in the same cycle.
- An in-flight owner tag (1 bit plus a valid bit) steers `rom_rgb` to the correct slot. At most one read is in flight per cycle.
- Requesters must not make `req_valid` depend on `req_ready`. `req_colour` must be stable while `req_valid` is high and not yet accepted.

## Timing
- Cycle T: handshake, `rom_en` = 1.
- Cycle T+1: ROM data available.
- Cycle T+2: `rspN_valid` = 1. Accept-to-response latency is 2 cycles.
- Per-requester throughput with `rsp_ready` tied to 1 is one lookup per 2 cycles. With both requesters streaming, grants alternate 0,1,0,1 and `rom_en` stays high every cycle.
- Reset values: `req0_ready`, `req1_ready`, `rsp0_valid`, `rsp1_valid`, `rom_en` = 0; `rsp0_rgb`, `rsp1_rgb`, `rom_addr` = 0; slots IDLE; pointer favours requester 0; in-flight tag invalid.
- Reset mid-operation: in-flight reads are discarded and held responses are dropped. ROM data in the cycle after reset is ignored.
- Requester in HOLD with `rsp_ready` = 0: it is not eligible, and the other requester may be granted every cycle.

## Structure
- Shared package `colour_pkg`:
  - `COL_W`, `RGB_W` constants.
  - Named colour codes (black = 0 … white = 7).
  - Slot state enum IDLE/FLIGHT/HOLD.
- Sub-module `rr_arb2`: two-way round-robin arbiter.
  - Inputs: eligible[1:0], clk, rst.
  - Output: one-hot grant[1:0].
  - Owns the pointer.
- The top level holds both slot FSMs, response registers, the in-flight tag and the ROM mux.

## Test plan
The bench ROM model is 1-cycle latency with entries 0:000000, 1:0000FF, 2:00FF00, 3:00FFFF, 4:FF0000, 5:FF00FF, 6:FFFF00, 7:FFFFFF.
- **Single lookup:** release reset, `req0_valid` = 1, colour 4, `rsp0_ready` = 1.
  - Expect `req0_ready` = 1, `rom_en` = 1, `rom_addr` = 4 in cycle T.
  - Expect `rsp0_valid` = 1, `rsp0_rgb` = FF0000 at T+2, then `rsp0_valid` = 0.
- **Simultaneous first requests:** both valid in the first cycle after reset, colours 1 and 6.
  - Expect requester 0 granted first, requester 1 in the next cycle.
  - Expect `rsp0_rgb` = 0000FF, then `rsp1_rgb` = FFFF00 one cycle later.
- **Continuous streaming:** both valid continuously, both `rsp_ready` = 1, 20 cycles.
  - Expect grants to alternate strictly and `rom_en` to stay high every cycle after the first.
  - Expect each response to match its colour.
- **Backpressure:** `rsp0_ready` = 0 after the first response (colour 2), requester 1 streaming colour 7.
  - Expect `rsp0_rgb` held at 00FF00 and `req0_ready` = 0.
  - Expect requester 1 granted every eligible cycle.
  - Release `rsp0_ready`: requester 0 is re-accepted in that same cycle.
- **Reset mid-flight:** assert `rst` in the cycle after the grant for colour 3.
  - Expect all outputs 0 next cycle and no `rsp_valid` for colour 3.
  - Expect the first post-reset tie to grant requester 0.
